// File: rtl/one_hot_pkg.sv
// Shared helpers for the one-hot demux: select legality check and counter width.
// Pure declarations, no timing; no flow control lives here.
// Used by one_hot_demux_2d and one_hot_demux_lane.
package one_hot_pkg;

   localparam int DROP_CNT_W = 8;
   localparam int SEL_MAX    = 32;

   // Exactly one bit set; callers zero-extend narrower selects to SEL_MAX.
   function automatic logic onehot_legal(input logic [SEL_MAX-1:0] sel);
      return (sel != '0) && ((sel & (sel - SEL_MAX'(1))) == '0);
   endfunction

endpackage

// File: rtl/one_hot_demux_lane.sv
// One-entry output register slice for a single demux lane.
// Latency: 1 cycle, wr_en to vld. Backpressure: holds data/vld until rdy; write and drain may coincide.
// The owner gates wr_en so that a full, stalled lane is never overwritten.
module one_hot_demux_lane
   import one_hot_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             vld,
   input  logic             rdy,
   output logic [WIDTH-1:0] data
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld  <= 1'b0;
         data <= '0;
      end else begin
         if (wr_en) begin
            vld  <= 1'b1;
            data <= wr_data;
         end else if (rdy) begin
            vld  <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/one_hot_demux_2d.sv
// Registered one-hot demux: steers din to the lane named by sel; illegal selects are dropped and flagged.
// Latency: 1 cycle din to dout_vld. Backpressure: din_rdy follows the selected lane only, never din_vld.
// Optional macro ONE_HOT_DEMUX_CNT_EN adds a saturating drop_cnt output.
module one_hot_demux_2d
   import one_hot_pkg::*;
#(
   parameter int WIDTH         = 32,
   parameter int CNT           = 5,
   parameter int ONE_HOT_CHECK = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic [CNT-1:0]   sel,
   input  logic             din_vld,
   output logic             din_rdy,
   output logic [WIDTH-1:0] dout [CNT],
   output logic [CNT-1:0]   dout_vld,
   input  logic [CNT-1:0]   dout_rdy,
   input  logic             err_clr,
   output logic             err,
   output logic             err_sticky
`ifdef ONE_HOT_DEMUX_CNT_EN
   ,
   output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

   logic [SEL_MAX-1:0] sel_ext;
   logic               sel_legal;
   logic [CNT-1:0]     lane_free;
   logic [CNT-1:0]     wr_en;
   logic               drop;

   always_comb begin
      sel_ext          = '0;
      sel_ext[CNT-1:0] = sel;
   end

   assign sel_legal = onehot_legal(sel_ext);
   assign lane_free = ~dout_vld | dout_rdy;

   generate
      if (ONE_HOT_CHECK != 0) begin : g_chk
         // Illegal words are always taken so they can be discarded without stalling.
         assign din_rdy = sel_legal ? |(sel & lane_free) : 1'b1;
         assign drop    = din_vld & ~sel_legal;
      end else begin : g_nochk
         // Multi-hot broadcasts, so every selected lane must have room.
         assign din_rdy = &(~sel | lane_free);
         assign drop    = 1'b0;
      end
   endgenerate

   assign wr_en = (din_vld & din_rdy & ~drop) ? sel : '0;

   for (genvar k = 0; k < CNT; k++) begin : g_lane
      one_hot_demux_lane #(
         .WIDTH (WIDTH)
      ) u_lane (
         .clk     (clk),
         .rst_n   (rst_n),
         .wr_en   (wr_en[k]),
         .wr_data (din),
         .vld     (dout_vld[k]),
         .rdy     (dout_rdy[k]),
         .data    (dout[k])
      );
   end

   // A drop coinciding with err_clr keeps the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err        <= 1'b0;
         err_sticky <= 1'b0;
      end else begin
         err <= drop;
         if (drop) begin
            err_sticky <= 1'b1;
         end else if (err_clr) begin
            err_sticky <= 1'b0;
         end
      end
   end

`ifdef ONE_HOT_DEMUX_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= '0;
      end else if (drop) begin
         if (err_clr) begin
            drop_cnt <= DROP_CNT_W'(1);
         end else if (drop_cnt != {DROP_CNT_W{1'b1}}) begin
            drop_cnt <= drop_cnt + DROP_CNT_W'(1);
         end
      end else if (err_clr) begin
         drop_cnt <= '0;
      end
   end
`endif

endmodule

// File: doc/one_hot_demux_2d.md
Name: one_hot_demux_2d

Overview:
- Registered one-hot demultiplexer: the scatter side paired with the gather-side one-hot mux.
- Accepts one WIDTH-bit word per cycle under a valid/ready handshake and steers it to the output lane named by a one-hot select.
- Each of CNT lanes has a one-entry output register with its own valid/ready handshake.
- Illegal (zero or multi-hot) selects are detected, dropped and flagged.

Parameters:
- WIDTH, 32, data word width in bits.
- CNT, 5, number of output lanes (2..32).
- ONE_HOT_CHECK, 1, 1 = detect illegal select, drop the word, flag err; 0 = no check, err tied 0, multi-hot select broadcasts to every selected lane.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  WIDTH  input word.
- sel  input  CNT  one-hot lane select, qualified by din_vld.
- din_vld  input  1  input word valid.
- din_rdy  output  1  input word accepted when din_vld & din_rdy.
- dout  output  [WIDTH-1:0] x [CNT-1:0] (unpacked array)  per-lane output data.
- dout_vld  output  CNT  per-lane output valid.
- dout_rdy  input  CNT  per-lane consumer ready.
- err_clr  input  1  clears err_sticky.
- err  output  1  one-cycle registered pulse per dropped illegal word.
- err_sticky  output  1  set on any dropped word; held until err_clr.

Behaviour:
- Reset (rst_n low, asynchronous): dout_vld=0, every dout lane=0, err=0, err_sticky=0.
- din_rdy is combinational, but never from din_vld:
  - legal sel[k]: din_rdy = ~dout_vld[k] | dout_rdy[k].
  - illegal sel (ONE_HOT_CHECK=1): din_rdy = 1.
  - ONE_HOT_CHECK=0: din_rdy = AND over selected lanes of (~dout_vld | dout_rdy); sel==0 gives din_rdy=1 and the word is silently dropped.
- Illegal sel: sel==0, or popcount(sel)>1.
- Accept into lane k: dout[k]<=din and dout_vld[k]<=1 on the same edge. Latency 1 cycle, din to dout_vld.
- Drain: dout_vld[k] & dout_rdy[k] with no new write to lane k gives dout_vld[k]<=0. dout[k] keeps its last value.
- Simultaneous drain and write on lane k: the new word is loaded and dout_vld[k] stays 1. Each lane sustains 1 word/cycle.
- Full lane, not selected: holds dout[k] and dout_vld[k] stable until dout_rdy[k]. Writes to other lanes proceed independently.
- Dropped illegal word (ONE_HOT_CHECK=1): no lane is modified. err<=1 for exactly one cycle, err_sticky<=1.
- err_clr in the same cycle as a new drop: set wins, so err_sticky stays 1.
- din_vld=0: sel and din are ignored, no state change.
- Reset mid-transfer: all held words are lost and no valid is asserted after reset. Upstream must re-send.

Optional Feature:
- Macro: ONE_HOT_DEMUX_CNT_EN.
- Defined: adds output port drop_cnt (8 bits). It is a saturating count of dropped illegal words, reset to 0, cleared by err_clr. Set wins on a coincident drop, so it loads 1.
- Undefined: port and logic absent. All other behaviour identical.

Decomposition:
- Shared package one_hot_pkg:
  - function onehot_legal(sel) returning 1 iff exactly one bit is set.
  - localparam DROP_CNT_W = 8.
- Sub-module one_hot_demux_lane: one-entry register slice with ports clk, rst_n, wr_en, wr_data, vld, rdy, data.
  - Instantiated CNT times in a generate loop.
  - Top level holds select decode, din_rdy and error logic.

Test Plan (WIDTH=32, CNT=5):
- Reset, then din=32'hA5A5_0001, sel=5'b00100, din_vld=1, all dout_rdy=1 -> next cycle dout_vld=5'b00100, dout[2]=32'hA5A5_0001, other lanes 0.
- Lane 1 full with dout_rdy[1]=0, send sel=5'b00010 -> din_rdy=0, dout[1] unchanged. Raise dout_rdy[1] -> word accepted, lane 1 data replaced with vld held 1 (back-to-back).
- Lane 1 full and stalled, send sel=5'b01000 -> accepted into lane 3 while lane 1 keeps vld=1 and its data.
- sel=5'b00110 with din_vld=1 -> din_rdy=1, no lane changes, err=1 for one cycle, err_sticky=1. Then err_clr=1 -> err_sticky=0.
- sel=5'b00000, then err_clr=1 coincident with another sel=5'b10001 -> err_sticky stays 1; with ONE_HOT_DEMUX_CNT_EN, drop_cnt=1.
- Stream 300 illegal words with ONE_HOT_DEMUX_CNT_EN -> drop_cnt saturates at 255. Assert rst_n low mid-stream -> all outputs 0 immediately, asynchronously.
